// File: rtl/reg_wb_ctrl_pkg.sv
// Shared CPU definitions: register index width, read-side FSM states and a
// scoreboard mask helper.
package reg_wb_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } rd_state_t;

    // One-hot scoreboard mask; x0 never maps to a bit so it can never go busy.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_IDX_W-1:0] idx);
        reg_mask = '0;
        if (idx != '0) begin
            reg_mask[idx] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Result queue between execute and register-file write-back. The head is read
// straight from registered storage and reads as zero while empty.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign valid = (count != '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file read/write-back controller: busy scoreboard for issue hazards,
// a strobed read request FSM and a queued write-back path.
module reg_wb_ctrl
    import reg_wb_ctrl_pkg::*;
#(
    parameter int LEN   = 32,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_in,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rs1,
    input  logic [REG_IDX_W-1:0] iss_rs2,
    input  logic [REG_IDX_W-1:0] iss_rd,
    output logic                 iss_ready,
    input  logic                 res_valid,
    input  logic [REG_IDX_W-1:0] res_rd,
    input  logic [LEN-1:0]       res_data,
    output logic                 res_ready,
    output logic [REG_IDX_W-1:0] rf_rs1,
    output logic [REG_IDX_W-1:0] rf_rs2,
    output logic                 rf_ex_signal,
    input  logic                 rf_stall,
    output logic                 rf_wb_flag,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [LEN-1:0]       rf_data,
    output logic                 err
);

    rd_state_t           state;
    logic [NUM_REGS-1:0] busy;
    logic                fifo_full;
    logic                iss_fire;
    logic                res_fire;
    logic                push;
    logic                pop;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign iss_ready = (state == IDLE) && !busy[iss_rs1] && !busy[iss_rs2]
                       && !busy[iss_rd] && rdy_in;
    assign res_ready = !fifo_full && rdy_in;
    assign iss_fire  = iss_valid && iss_ready;
    assign res_fire  = res_valid && res_ready;
    assign push      = res_fire && (res_rd != '0);
    assign pop       = rf_wb_flag && !rf_stall && rdy_in;
    assign set_mask  = iss_fire ? reg_mask(iss_rd) : '0;
    assign clr_mask  = pop ? reg_mask(rf_rd) : '0;

    wb_fifo #(
        .WIDTH (LEN + REG_IDX_W),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({res_rd, res_data}),
        .rdata ({rf_rd, rf_data}),
        .valid (rf_wb_flag),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rf_ex_signal <= 1'b0;
            rf_rs1       <= '0;
            rf_rs2       <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (iss_fire) begin
                        rf_rs1       <= iss_rs1;
                        rf_rs2       <= iss_rs2;
                        rf_ex_signal <= 1'b1;
                        state        <= STROBE;
                    end
                end
                STROBE: begin
                    rf_ex_signal <= 1'b0;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (!rf_stall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    rf_ex_signal <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Clear before set, so a same-edge issue to the register being retired stays busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            if (push && !busy[res_rd]) begin
                err <= 1'b1;
            end
        end
    end

endmodule
